// File: rtl/kabeta_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kabeta_pipe_pkg
// Brief   : Shared types for the Kabeta elastic pipeline register.
// Revision: 1.0
// ============================================================================
package kabeta_pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } skid_state_t;

    function automatic logic [OCC_W-1:0] state_occ(input skid_state_t s);
        case (s)
            EMPTY:   state_occ = 2'd0;
            BUSY:    state_occ = 2'd1;
            FULL:    state_occ = 2'd2;
            default: state_occ = 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_skid_ctrl
// Brief   : Occupancy FSM of the skid register; emits data-path load strobes.
//           Flush input exists only when PIPE_SKID_FLUSH_EN is defined.
// Revision: 1.0
// ============================================================================
module pipe_skid_ctrl
    import kabeta_pipe_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        InValid,
    input  logic        OutReady,
`ifdef PIPE_SKID_FLUSH_EN
    input  logic        Flush,
`endif
    output skid_state_t state,
    output logic        load_main,
    output logic        load_skid,
    output logic        main_from_skid
);

    skid_state_t state_q;
    skid_state_t state_d;
    logic        in_xfer;
    logic        out_xfer;

    assign state    = state_q;
    assign in_xfer  = InValid  && (state_q != FULL);
    assign out_xfer = OutReady && (state_q != EMPTY);

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    load_main = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (out_xfer) begin
                    state_d   = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_from_skid = 1'b1;
                    state_d        = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
`ifdef PIPE_SKID_FLUSH_EN
        // Flush overrides everything; a same-cycle input is silently dropped.
        if (Flush) begin
            state_d        = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
`endif
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_skid_reg
// Brief   : Elastic pipeline register with registered InReady and one-entry skid.
//           Optional Flush port enabled by PIPE_SKID_FLUSH_EN.
// Revision: 1.0
// ============================================================================
module pipe_skid_reg
    import kabeta_pipe_pkg::*;
#(
    parameter int                WID_DATA   = 32,
    parameter logic [WID_DATA-1:0] RESET_DATA = '0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                InValid,
    output logic                InReady,
    input  logic [WID_DATA-1:0] DataIn,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [WID_DATA-1:0] DataOut,
`ifdef PIPE_SKID_FLUSH_EN
    input  logic                Flush,
`endif
    output logic [OCC_W-1:0]    Occupancy
);

    skid_state_t         state;
    logic                load_main;
    logic                load_skid;
    logic                main_from_skid;
    logic [WID_DATA-1:0] main_q;
    logic [WID_DATA-1:0] main_d;
    logic [WID_DATA-1:0] skid_q;
    logic [WID_DATA-1:0] skid_d;

    pipe_skid_ctrl u_ctrl (
        .Clock          (Clock),
        .Reset          (Reset),
        .InValid        (InValid),
        .OutReady       (OutReady),
`ifdef PIPE_SKID_FLUSH_EN
        .Flush          (Flush),
`endif
        .state          (state),
        .load_main      (load_main),
        .load_skid      (load_skid),
        .main_from_skid (main_from_skid)
    );

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (main_from_skid) begin
            main_d = skid_q;
        end else if (load_main) begin
            main_d = DataIn;
        end
        if (load_skid) begin
            skid_d = DataIn;
        end
`ifdef PIPE_SKID_FLUSH_EN
        if (Flush) begin
            main_d = RESET_DATA;
            skid_d = RESET_DATA;
        end
`endif
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            main_q <= RESET_DATA;
            skid_q <= RESET_DATA;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // Handshake outputs are pure decodes of the state flops, keeping InReady registered.
    assign InReady   = (state != FULL);
    assign OutValid  = (state != EMPTY);
    assign Occupancy = state_occ(state);
    assign DataOut   = main_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_skid_reg
// Brief   : Self-checking bench for pipe_skid_reg against a queue-based model.
// Revision: 1.0
// ============================================================================
module tb_pipe_skid_reg;

    localparam int          WID_DATA   = 32;
    localparam logic [31:0] RESET_DATA = 32'h5A5A_0000;

    logic        Clock;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [31:0] DataIn;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] DataOut;
    logic        Flush;
    logic [1:0]  Occupancy;

    pipe_skid_reg #(
        .WID_DATA   (WID_DATA),
        .RESET_DATA (RESET_DATA)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .InValid   (InValid),
        .InReady   (InReady),
        .DataIn    (DataIn),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .DataOut   (DataOut),
`ifdef PIPE_SKID_FLUSH_EN
        .Flush     (Flush),
`endif
        .Occupancy (Occupancy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] model_q[$];
    logic [31:0] model_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] exp_data;
        exp_data = (model_q.size() > 0) ? model_q[0] : model_last;
        check({tag, ".in_ready"},  32'(InReady),   32'(model_q.size() < 2));
        check({tag, ".out_valid"}, 32'(OutValid),  32'(model_q.size() > 0));
        check({tag, ".occupancy"}, 32'(Occupancy), 32'(model_q.size()));
        check({tag, ".data_out"},  DataOut,        exp_data);
    endtask

    task automatic model_reset();
        model_q.delete();
        model_last = RESET_DATA;
    endtask

    // One clock: drive, update the model at the edge, check just after it.
    task automatic step(input logic iv, input logic [31:0] d, input logic ordy,
                        input logic fl, input string tag);
        logic        prev_ov;
        logic [31:0] prev_do;
        logic        in_x;
        logic        out_x;
        InValid  = iv;
        DataIn   = d;
        OutReady = ordy;
        Flush    = fl;
        prev_ov  = OutValid;
        prev_do  = DataOut;
        @(posedge Clock);
        in_x  = iv   && (model_q.size() < 2);
        out_x = ordy && (model_q.size() > 0);
        if (out_x) model_last = model_q.pop_front();
        if (fl) begin
            model_reset();
        end else if (in_x) begin
            model_q.push_back(d);
        end
        #1;
        check_outputs(tag);
        if (prev_ov && !ordy && !fl) begin
            check({tag, ".stable_valid"}, 32'(OutValid), 32'h1);
            check({tag, ".stable_data"},  DataOut,       prev_do);
        end
    endtask

    initial begin
        logic        cur_iv;
        logic [31:0] cur_d;
        logic        cur_fl;
        logic        hold;

        Reset = 1'b1; InValid = 1'b0; DataIn = '0; OutReady = 1'b0; Flush = 1'b0;
        model_reset();
        #12;
        check_outputs("reset_init");
        Reset = 1'b0;
        #3;

        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b1, 1'b0, "stream");
        check("stream.last_data", DataOut, 32'h8);
        step(1'b0, 32'h0, 1'b1, 1'b0, "drain");
        check("drain.out_valid", 32'(OutValid), 32'h0);
        check("drain.keep_data", DataOut, 32'h8);

        step(1'b1, 32'h11, 1'b0, 1'b0, "stall");
        step(1'b1, 32'h22, 1'b0, 1'b0, "stall");
        check("stall.full_ready", 32'(InReady), 32'h0);
        step(1'b1, 32'h33, 1'b0, 1'b0, "stall_hold");
        step(1'b1, 32'h33, 1'b1, 1'b0, "unstall");
        check("unstall.data22", DataOut, 32'h22);
        step(1'b1, 32'h33, 1'b1, 1'b0, "unstall");
        check("unstall.data33", DataOut, 32'h33);
        step(1'b0, 32'h0, 1'b1, 1'b0, "unstall_drain");

        step(1'b1, 32'h5, 1'b0, 1'b0, "simul");
        step(1'b1, 32'h6, 1'b1, 1'b0, "simul");
        check("simul.data6", DataOut, 32'h6);
        check("simul.occ1", 32'(Occupancy), 32'h1);

        // Asynchronous reset while FULL, checked before any further edge.
        step(1'b1, 32'hA, 1'b0, 1'b0, "prefill");
        step(1'b1, 32'hB, 1'b0, 1'b0, "prefill");
        #2 Reset = 1'b1;
        model_reset();
        #1;
        check_outputs("async_reset");
        #2 Reset = 1'b0;
        InValid = 1'b0;

`ifdef PIPE_SKID_FLUSH_EN
        @(posedge Clock); #1;
        step(1'b1, 32'hA, 1'b0, 1'b0, "fl_fill");
        step(1'b1, 32'hB, 1'b0, 1'b0, "fl_fill");
        step(1'b1, 32'h77, 1'b0, 1'b1, "flush");
        check("flush.data_reset", DataOut, RESET_DATA);
        step(1'b0, 32'h0, 1'b1, 1'b0, "post_flush");
        check("post_flush.no_77", 32'(OutValid), 32'h0);
`endif

        cur_iv = 1'b0; cur_d = '0; cur_fl = 1'b0; hold = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                cur_iv = ($urandom_range(0, 99) < 70);
                cur_d  = $urandom;
            end
`ifdef PIPE_SKID_FLUSH_EN
            cur_fl = ($urandom_range(0, 99) < 2);
`endif
            hold = cur_iv && (model_q.size() >= 2);
            step(cur_iv, cur_d, ($urandom_range(0, 99) < 60), cur_fl, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
